// File: rtl/log_taylor_npp_if.sv
// Operand/result bundle for the natural-log unit.
// Latency: n/a (wiring only).
// Backpressure: oReady from the slave gates iDataValid from the master.
interface log_taylor_npp_if;
  logic [15:0] iData;
  logic        iDataValid;
  logic        oReady;
  logic [11:0] oData;
  logic        oDataValid;

  modport master (
    output iData,
    output iDataValid,
    input  oReady,
    input  oData,
    input  oDataValid
  );

  modport slave (
    input  iData,
    input  iDataValid,
    output oReady,
    output oData,
    output oDataValid
  );
endinterface

// File: rtl/log_taylor_npp.sv
// Natural-log unit: unsigned Q8.8 operand in, signed Q3.8 ln(x) out, one shared 17x17 multiplier.
// Latency: result pulse on the (2*TERMS+2)th edge after the accepting edge; one operand in flight.
// Backpressure: oReady low while busy; iDataValid is ignored (not queued) when oReady=0.
module log_taylor_npp #(
  parameter int TERMS = 5
) (
  input  logic            clk,
  input  logic            rst,
  log_taylor_npp_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_MUL   = 3'd2,
    S_ACC   = 3'd3,
    S_SCALE = 3'd4
  } state_t;

  // 1.0 in the Q1.15 power register (needs the 17th bit, hence 17-bit pow/f).
  localparam logic signed [16:0] ONE_Q15 = 17'sh08000;
  // ln(2) in Q0.16, widened to the scaling datapath width.
  localparam logic signed [25:0] LN2_Q16 = 26'sd45426;
  localparam logic signed [25:0] HALF_LSB = 26'sd128;
  localparam logic signed [25:0] SAT_MAX  = 26'sd2047;
  localparam logic signed [25:0] SAT_MIN  = -26'sd2048;

  // 1/n in Q0.16. 1/1 does not fit Q0.16, so it saturates to 0xFFFF;
  // the resulting error is below one Q0.16 LSB of the first term.
  function automatic logic signed [16:0] recip(input logic [3:0] n);
    logic signed [16:0] r;
    case (n)
      4'd1:    r = 17'sd65535;
      4'd2:    r = 17'sd32768;
      4'd3:    r = 17'sd21845;
      4'd4:    r = 17'sd16384;
      4'd5:    r = 17'sd13107;
      4'd6:    r = 17'sd10923;
      4'd7:    r = 17'sd9362;
      default: r = 17'sd0;
    endcase
    return r;
  endfunction

  // Control and datapath registers.
  state_t             state_q, state_d;
  logic [15:0]        op_q, op_d;
  logic               zero_q, zero_d;
  logic signed [4:0]  k_q, k_d;
  logic signed [16:0] f_q, f_d;
  logic signed [16:0] pow_q, pow_d;
  logic signed [20:0] acc_q, acc_d;
  logic [3:0]         n_q, n_d;
  logic [11:0]        data_q, data_d;
  logic               vld_q, vld_d;
  logic               rdy_q, rdy_d;

  // Combinational datapath nets.
  logic               accept;
  logic [3:0]         lead;
  logic [15:0]        norm;
  logic signed [4:0]  k_norm;
  logic signed [16:0] f_norm;
  logic signed [16:0] mul_b;
  logic signed [33:0] prod;
  logic signed [20:0] term;
  logic signed [25:0] acc_ext;
  logic signed [25:0] k_ext;
  logic signed [25:0] r_sum;
  logic signed [25:0] r_rnd;
  logic [11:0]        r_sat;
  logic               unused_prod_lsbs;

  // Only the idle state with oReady high takes a new operand.
  assign accept = (state_q == S_IDLE) && rdy_q && io.iDataValid;

  // Normalise the operand to m*2^k with m in [0.75,1.5); f = m-1 in Q1.15.
  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (op_q[i]) lead = 4'(i);
    end
    norm   = op_q << (4'd15 - lead);
    k_norm = $signed({1'b0, lead}) - 5'sd8;
    f_norm = 17'sd0;
    if (op_q == 16'd0) begin
      // Zero has no logarithm; run the series on f=0 and override at SCALE.
      k_norm = 5'sd0;
      f_norm = 17'sd0;
    end else if (norm[14]) begin
      // m >= 1.5: halve m and bump the exponent to keep f small.
      k_norm = k_norm + 5'sd1;
      f_norm = $signed({2'b00, norm[15:1]}) - ONE_Q15;
    end else begin
      f_norm = $signed({1'b0, norm}) - ONE_Q15;
    end
  end

  // Single shared multiplier: pow*f in MUL, pow*(1/n) in ACC.
  assign mul_b = (state_q == S_ACC) ? recip(n_q) : f_q;
  assign prod  = pow_q * mul_b;
  assign term  = {{2{prod[33]}}, prod[33:15]};
  assign unused_prod_lsbs = ^prod[14:0];

  // Final scaling: add k*ln2, round half-up to Q3.8 and saturate to 12 bits.
  always_comb begin
    acc_ext = {{5{acc_q[20]}}, acc_q};
    k_ext   = {{21{k_q[4]}}, k_q};
    r_sum   = acc_ext + k_ext * LN2_Q16;
    r_rnd   = (r_sum + HALF_LSB) >>> 8;
    if (r_rnd > SAT_MAX) begin
      r_sat = 12'h7FF;
    end else if (r_rnd < SAT_MIN) begin
      r_sat = 12'h800;
    end else begin
      r_sat = r_rnd[11:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE -> NORM -> {MUL,ACC} x TERMS -> SCALE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_NORM;
      S_NORM:  state_d = S_MUL;
      S_MUL:   state_d = S_ACC;
      S_ACC:   state_d = (n_q < 4'(TERMS)) ? S_MUL : S_SCALE;
      S_SCALE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the datapath and handshake registers.
  always_comb begin
    op_d   = op_q;
    zero_d = zero_q;
    k_d    = k_q;
    f_d    = f_q;
    pow_d  = pow_q;
    acc_d  = acc_q;
    n_d    = n_q;
    data_d = data_q;
    vld_d  = 1'b0;
    rdy_d  = rdy_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = io.iData;
          rdy_d = 1'b0;
        end
      end
      S_NORM: begin
        zero_d = (op_q == 16'd0);
        k_d    = k_norm;
        f_d    = f_norm;
        pow_d  = ONE_Q15;
        acc_d  = 21'sd0;
        n_d    = 4'd1;
      end
      S_MUL: begin
        pow_d = prod[31:15];
      end
      S_ACC: begin
        // Alternating series: odd terms add, even terms subtract.
        acc_d = n_q[0] ? (acc_q + term) : (acc_q - term);
        n_d   = n_q + 4'd1;
      end
      S_SCALE: begin
        data_d = zero_q ? 12'h800 : r_sat;
        vld_d  = 1'b1;
        rdy_d  = 1'b1;
      end
      default: begin
        rdy_d = 1'b1;
      end
    endcase
  end

  // Datapath and handshake registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 16'd0;
      zero_q <= 1'b0;
      k_q    <= 5'sd0;
      f_q    <= 17'sd0;
      pow_q  <= 17'sd0;
      acc_q  <= 21'sd0;
      n_q    <= 4'd0;
      data_q <= 12'd0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      op_q   <= op_d;
      zero_q <= zero_d;
      k_q    <= k_d;
      f_q    <= f_d;
      pow_q  <= pow_d;
      acc_q  <= acc_d;
      n_q    <= n_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      rdy_q  <= rdy_d;
    end
  end

  assign io.oReady    = rdy_q;
  assign io.oData     = data_q;
  assign io.oDataValid = vld_q;

endmodule

// File: tb/tb_log_taylor_npp.sv
// Self-checking bench for log_taylor_npp against a real-valued ln() reference.
// Latency: checks the 12-edge result latency and 13-cycle back-to-back spacing.
// Backpressure: checks that operands offered while busy are dropped.
module tb_log_taylor_npp;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  log_taylor_npp_if bus();

  log_taylor_npp #(.TERMS(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] k_din  [7] = '{16'd256, 16'd512, 16'd128, 16'd696, 16'd65535, 16'd1, 16'd0};
  int          k_want [7] = '{0, 177, -177, 256, 1420, -1420, -2048};
  int          k_tol  [7] = '{0, 0, 0, 2, 2, 2, 0};

  // Reference: round(256*ln(x/256)) clamped to Q3.8; zero maps to the most negative code.
  function automatic int ref_ln(input int x);
    real v;
    int  r;
    if (x == 0) return -2048;
    v = $ln(real'(x) / 256.0) * 256.0;
    r = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    if (r > 2047)  r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Offer one operand once idle, then count edges until the result pulse (lat stays 0 if no pulse).
  task automatic run_op(input logic [15:0] d, output logic [11:0] res, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (bus.oReady !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.iData = d;
    bus.iDataValid = 1'b1;
    @(posedge clk);
    #1;
    bus.iDataValid = 1'b0;
    lat = 0;
    res = 12'h000;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.oDataValid === 1'b1) begin
        lat = e;
        res = bus.oData;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iData = 16'd0;
    bus.iDataValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.oReady !== 1'b1) $display("FAIL reset_oReady got %b want 1", bus.oReady);
    else n_pass++;
    n_checks++;
    if (bus.oDataValid !== 1'b0) $display("FAIL reset_oDataValid got %b want 0", bus.oDataValid);
    else n_pass++;
    n_checks++;
    if (bus.oData !== 12'h000) $display("FAIL reset_oData got %h want 000", bus.oData);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known();
    logic [11:0] res;
    int lat;
    int got;
    for (int i = 0; i < 7; i++) begin
      run_op(k_din[i], res, lat);
      got = int'($signed(res));
      n_checks++;
      if (lat !== 12) $display("FAIL known_latency x=%0d got %0d want 12", k_din[i], lat);
      else n_pass++;
      n_checks++;
      if (abs_i(got - k_want[i]) > k_tol[i])
        $display("FAIL known_value x=%0d got %0d want %0d +/-%0d", k_din[i], got, k_want[i], k_tol[i]);
      else n_pass++;
      if (i == 0) begin
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.oDataValid !== 1'b0) $display("FAIL pulse_width got oDataValid=%b want 0", bus.oDataValid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] res;
    int lat;
    int x;
    int got;
    int want;
    for (int j = 0; j < 24; j++) begin
      x = (j % 3 == 0) ? int'($urandom_range(1, 255)) : int'($urandom_range(1, 65535));
      run_op(16'(x), res, lat);
      got  = int'($signed(res));
      want = ref_ln(x);
      n_checks++;
      if (lat !== 12) $display("FAIL random_latency x=%0d got %0d want 12", x, lat);
      else n_pass++;
      n_checks++;
      if (abs_i(got - want) > 2) $display("FAIL random_value x=%0d got %0d want %0d +/-2", x, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_busy();
    int bad_rdy;
    int pulses;
    int first_e;
    logic [11:0] got;
    @(negedge clk);
    bus.iData = 16'd512;
    bus.iDataValid = 1'b1;
    @(posedge clk);
    #1;
    bus.iDataValid = 1'b0;
    bad_rdy = 0;
    pulses  = 0;
    first_e = 0;
    got     = 12'h000;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (e == 5) begin
        bus.iData = 16'd384;
        bus.iDataValid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.iDataValid = 1'b0;
      if (e <= 11 && bus.oReady !== 1'b0) bad_rdy++;
      if (bus.oDataValid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          first_e = e;
          got = bus.oData;
        end
      end
    end
    n_checks++;
    if (bad_rdy != 0) $display("FAIL busy_oReady_low got %0d high edges want 0", bad_rdy);
    else n_pass++;
    n_checks++;
    if (pulses != 1) $display("FAIL busy_pulse_count got %0d want 1", pulses);
    else n_pass++;
    n_checks++;
    if (first_e != 12) $display("FAIL busy_latency got %0d want 12", first_e);
    else n_pass++;
    n_checks++;
    if (got !== 12'h0B1) $display("FAIL busy_value got %h want 0b1", got);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stale;
    logic [11:0] res;
    int lat;
    @(negedge clk);
    bus.iData = 16'd512;
    bus.iDataValid = 1'b1;
    @(posedge clk);
    #1;
    bus.iDataValid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.oReady !== 1'b1) $display("FAIL midreset_oReady got %b want 1", bus.oReady);
    else n_pass++;
    n_checks++;
    if (bus.oDataValid !== 1'b0) $display("FAIL midreset_oDataValid got %b want 0", bus.oDataValid);
    else n_pass++;
    n_checks++;
    if (bus.oData !== 12'h000) $display("FAIL midreset_oData got %h want 000", bus.oData);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (bus.oDataValid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL midreset_stale_pulse got %0d want 0", stale);
    else n_pass++;
    run_op(16'd256, res, lat);
    n_checks++;
    if (lat !== 12) $display("FAIL midreset_fresh_latency got %0d want 12", lat);
    else n_pass++;
    n_checks++;
    if (res !== 12'h000) $display("FAIL midreset_fresh_value got %h want 000", res);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int guard;
    int e1;
    int e2;
    logic [11:0] v1;
    logic [11:0] v2;
    logic rdy1;
    @(negedge clk);
    guard = 0;
    while (bus.oReady !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.iData = 16'd256;
    bus.iDataValid = 1'b1;
    @(posedge clk);
    #1;
    bus.iData = 16'd512;
    e1 = 0;
    e2 = 0;
    v1 = 12'h000;
    v2 = 12'h000;
    rdy1 = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (bus.oDataValid === 1'b1) begin
        if (e1 == 0) begin
          e1 = e;
          v1 = bus.oData;
          rdy1 = bus.oReady;
        end else begin
          e2 = e;
          v2 = bus.oData;
          bus.iDataValid = 1'b0;
          break;
        end
      end
    end
    bus.iDataValid = 1'b0;
    n_checks++;
    if (e1 != 12) $display("FAIL b2b_first_latency got %0d want 12", e1);
    else n_pass++;
    n_checks++;
    if (v1 !== 12'h000) $display("FAIL b2b_first_value got %h want 000", v1);
    else n_pass++;
    n_checks++;
    if (rdy1 !== 1'b1) $display("FAIL b2b_ready_in_valid_cycle got %b want 1", rdy1);
    else n_pass++;
    n_checks++;
    if (e2 - e1 != 13) $display("FAIL b2b_spacing got %0d want 13", e2 - e1);
    else n_pass++;
    n_checks++;
    if (v2 !== 12'h0B1) $display("FAIL b2b_second_value got %h want 0b1", v2);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.iData = 16'd0;
    bus.iDataValid = 1'b0;
    test_reset();
    test_known();
    test_random();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
